// File: rtl/cb_register_pkg.sv
// rtl/cb_register_pkg.sv - shared op-code definitions for the register bank and CPU control unit
package cb_register_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_LOAD = 3'd1,
        OP_INC  = 3'd2,
        OP_DEC  = 3'd3,
        OP_SHL  = 3'd4,
        OP_SHR  = 3'd5,
        OP_CLR  = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

endpackage

// File: rtl/cb_reg_op_unit.sv
// rtl/cb_reg_op_unit.sv - combinational next-value and carry computation for one register op
module cb_reg_op_unit
    import cb_register_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] old_val,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] new_val,
    output logic             carry,
    output logic             we
);

    // Decode the op; NOP and the reserved code leave we low so nothing is written
    always_comb begin
        new_val = old_val;
        carry   = 1'b0;
        we      = 1'b0;
        case (op_e'(op))
            OP_LOAD: begin
                new_val = data_in;
                we      = 1'b1;
            end
            OP_INC: begin
                // The extra top bit captures the wrap from all-ones to zero
                {carry, new_val} = {1'b0, old_val} + {{WIDTH{1'b0}}, 1'b1};
                we               = 1'b1;
            end
            OP_DEC: begin
                // Top bit becomes the borrow when old_val is zero
                {carry, new_val} = {1'b0, old_val} - {{WIDTH{1'b0}}, 1'b1};
                we               = 1'b1;
            end
            OP_SHL: begin
                new_val = {old_val[WIDTH-2:0], 1'b0};
                carry   = old_val[WIDTH-1];
                we      = 1'b1;
            end
            OP_SHR: begin
                new_val = {1'b0, old_val[WIDTH-1:1]};
                carry   = old_val[0];
                we      = 1'b1;
            end
            OP_CLR: begin
                new_val = '0;
                we      = 1'b1;
            end
            default: begin
                new_val = old_val;
            end
        endcase
    end

endmodule

// File: rtl/cb_register_bank.sv
// rtl/cb_register_bank.sv - register bank with one read-modify-write op per cycle and two read ports
module cb_register_bank
    import cb_register_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int AW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] data_out_a,
    output logic [WIDTH-1:0] data_out_b,
    output logic             flag_zero,
    output logic             flag_carry
);

    // One extra bit so DEPTH itself is representable for the range checks
    localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

    logic [WIDTH-1:0] regs [DEPTH];

    logic             wr_valid;
    logic             rd_valid_a;
    logic             rd_valid_b;
    logic [WIDTH-1:0] cur_val;
    logic [WIDTH-1:0] new_val;
    logic             carry;
    logic             we;

    assign wr_valid   = ({1'b0, wr_addr}   < DEPTH_L);
    assign rd_valid_a = ({1'b0, rd_addr_a} < DEPTH_L);
    assign rd_valid_b = ({1'b0, rd_addr_b} < DEPTH_L);

    // Out-of-range targets are never written, so their old value is irrelevant
    assign cur_val    = wr_valid ? regs[wr_addr] : '0;

    // Reads come straight from stored state; a same-cycle write is not bypassed
    assign data_out_a = rd_valid_a ? regs[rd_addr_a] : '0;
    assign data_out_b = rd_valid_b ? regs[rd_addr_b] : '0;

    cb_reg_op_unit #(
        .WIDTH (WIDTH)
    ) u_op_unit (
        .op      (op),
        .old_val (cur_val),
        .data_in (data_in),
        .new_val (new_val),
        .carry   (carry),
        .we      (we)
    );

    // Register and flag update; clear overrides any op in the same cycle
    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            flag_zero  <= 1'b0;
            flag_carry <= 1'b0;
        end else if (we && wr_valid) begin
            regs[wr_addr] <= new_val;
            flag_zero     <= (new_val == '0);
            flag_carry    <= carry;
        end
    end

endmodule

// File: tb/tb_cb_register_bank.sv
// tb/tb_cb_register_bank.sv - directed self-checking bench for cb_register_bank
module tb_cb_register_bank;

    logic       clk = 1'b0;
    logic       clear = 1'b0;
    logic [2:0] op = 3'd0;
    logic [1:0] wr_addr = 2'd0;
    logic [7:0] data_in = 8'h00;
    logic [1:0] rd_addr_a = 2'd0;
    logic [1:0] rd_addr_b = 2'd0;
    logic [7:0] data_out_a, data_out_b;
    logic       flag_zero, flag_carry;
    logic [7:0] data_out_a3, data_out_b3;
    logic       flag_zero3, flag_carry3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cb_register_bank #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .clear      (clear),
        .op         (op),
        .wr_addr    (wr_addr),
        .data_in    (data_in),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .data_out_a (data_out_a),
        .data_out_b (data_out_b),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry)
    );

    cb_register_bank #(.WIDTH(8), .DEPTH(3)) dut3 (
        .clk        (clk),
        .clear      (clear),
        .op         (op),
        .wr_addr    (wr_addr),
        .data_in    (data_in),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .data_out_a (data_out_a3),
        .data_out_b (data_out_b3),
        .flag_zero  (flag_zero3),
        .flag_carry (flag_carry3)
    );

    task automatic do_op(input logic [2:0] o, input logic [1:0] a, input logic [7:0] d);
        @(negedge clk);
        op = o; wr_addr = a; data_in = d;
        @(posedge clk);
        #1;
        op = 3'd0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1; op = 3'd0;
        @(posedge clk);
        #1;
        clear = 1'b0;
    endtask

    task automatic set_rd(input logic [1:0] a, input logic [1:0] b);
        rd_addr_a = a; rd_addr_b = b;
        #1;
    endtask

    task automatic test_reset();
        do_clear();
        for (int i = 0; i < 4; i++) begin
            set_rd(2'(i), 2'(3 - i));
            checks++;
            if (data_out_a !== 8'h00) begin errors++; $display("FAIL reset_a[%0d] got %h exp 00", i, data_out_a); end
            checks++;
            if (data_out_b !== 8'h00) begin errors++; $display("FAIL reset_b[%0d] got %h exp 00", i, data_out_b); end
        end
        checks++;
        if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {flag_zero, flag_carry}); end
    endtask

    task automatic test_load();
        do_op(3'd1, 2'd2, 8'hA5);
        set_rd(2'd2, 2'd0);
        checks++;
        if (data_out_a !== 8'hA5) begin errors++; $display("FAIL load_r2 got %h exp a5", data_out_a); end
        checks++;
        if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL load_flags got %b exp 00", {flag_zero, flag_carry}); end
        checks++;
        if (data_out_b !== 8'h00) begin errors++; $display("FAIL load_r0 got %h exp 00", data_out_b); end
        set_rd(2'd1, 2'd3);
        checks++;
        if (data_out_a !== 8'h00) begin errors++; $display("FAIL load_r1 got %h exp 00", data_out_a); end
        checks++;
        if (data_out_b !== 8'h00) begin errors++; $display("FAIL load_r3 got %h exp 00", data_out_b); end
    endtask

    task automatic test_inc_dec();
        do_op(3'd1, 2'd1, 8'hFF);
        do_op(3'd2, 2'd1, 8'h00);
        set_rd(2'd1, 2'd2);
        checks++;
        if (data_out_a !== 8'h00) begin errors++; $display("FAIL inc_wrap got %h exp 00", data_out_a); end
        checks++;
        if ({flag_zero, flag_carry} !== 2'b11) begin errors++; $display("FAIL inc_flags got %b exp 11", {flag_zero, flag_carry}); end
        checks++;
        if (data_out_b !== 8'hA5) begin errors++; $display("FAIL inc_hold_r2 got %h exp a5", data_out_b); end
        do_op(3'd3, 2'd1, 8'h00);
        checks++;
        if (data_out_a !== 8'hFF) begin errors++; $display("FAIL dec_wrap got %h exp ff", data_out_a); end
        checks++;
        if ({flag_zero, flag_carry} !== 2'b01) begin errors++; $display("FAIL dec_flags got %b exp 01", {flag_zero, flag_carry}); end
        do_op(3'd3, 2'd1, 8'h00);
        checks++;
        if (data_out_a !== 8'hFE || flag_carry !== 1'b0) begin errors++; $display("FAIL dec_plain got %h/%b exp fe/0", data_out_a, flag_carry); end
    endtask

    task automatic test_shift();
        do_op(3'd1, 2'd3, 8'h81);
        set_rd(2'd3, 2'd3);
        do_op(3'd4, 2'd3, 8'h00);
        checks++;
        if (data_out_a !== 8'h02 || {flag_zero, flag_carry} !== 2'b01) begin errors++; $display("FAIL shl got %h/%b exp 02/01", data_out_a, {flag_zero, flag_carry}); end
        do_op(3'd5, 2'd3, 8'h00);
        checks++;
        if (data_out_b !== 8'h01 || {flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL shr1 got %h/%b exp 01/00", data_out_b, {flag_zero, flag_carry}); end
        do_op(3'd5, 2'd3, 8'h00);
        checks++;
        if (data_out_a !== 8'h00 || {flag_zero, flag_carry} !== 2'b11) begin errors++; $display("FAIL shr2 got %h/%b exp 00/11", data_out_a, {flag_zero, flag_carry}); end
        do_op(3'd1, 2'd3, 8'h40);
        do_op(3'd6, 2'd3, 8'h00);
        checks++;
        if (data_out_a !== 8'h00 || {flag_zero, flag_carry} !== 2'b10) begin errors++; $display("FAIL clr got %h/%b exp 00/10", data_out_a, {flag_zero, flag_carry}); end
    endtask

    task automatic test_no_bypass();
        do_clear();
        set_rd(2'd0, 2'd0);
        @(negedge clk);
        op = 3'd1; wr_addr = 2'd0; data_in = 8'h10;
        #1;
        checks++;
        if (data_out_a !== 8'h00) begin errors++; $display("FAIL bypass_pre got %h exp 00", data_out_a); end
        @(posedge clk);
        #1;
        op = 3'd0;
        checks++;
        if (data_out_a !== 8'h10) begin errors++; $display("FAIL bypass_post got %h exp 10", data_out_a); end
        do_op(3'd7, 2'd0, 8'hFF);
        checks++;
        if (data_out_a !== 8'h10 || {flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL reserved_op got %h/%b exp 10/00", data_out_a, {flag_zero, flag_carry}); end
        do_op(3'd0, 2'd0, 8'hFF);
        checks++;
        if (data_out_b !== 8'h10) begin errors++; $display("FAIL nop got %h exp 10", data_out_b); end
    endtask

    task automatic test_clear_override();
        do_op(3'd1, 2'd1, 8'hFF);
        do_op(3'd2, 2'd1, 8'h00);
        do_op(3'd1, 2'd2, 8'h77);
        @(negedge clk);
        clear = 1'b1; op = 3'd1; wr_addr = 2'd2; data_in = 8'h33;
        @(posedge clk);
        #1;
        clear = 1'b0;
        set_rd(2'd2, 2'd0);
        checks++;
        if (data_out_a !== 8'h00 || data_out_b !== 8'h00) begin errors++; $display("FAIL clear_override got %h,%h exp 00,00", data_out_a, data_out_b); end
        checks++;
        if ({flag_zero, flag_carry} !== 2'b00) begin errors++; $display("FAIL clear_flags got %b exp 00", {flag_zero, flag_carry}); end
        do_op(3'd1, 2'd2, 8'h33);
        checks++;
        if (data_out_a !== 8'h33) begin errors++; $display("FAIL resume_load got %h exp 33", data_out_a); end
    endtask

    task automatic test_depth3();
        do_clear();
        do_op(3'd1, 2'd1, 8'hFF);
        do_op(3'd2, 2'd1, 8'h00);
        do_op(3'd1, 2'd3, 8'h77);
        set_rd(2'd0, 2'd3);
        checks++;
        if ({flag_zero3, flag_carry3} !== 2'b11) begin errors++; $display("FAIL d3_flags got %b exp 11", {flag_zero3, flag_carry3}); end
        checks++;
        if (data_out_b3 !== 8'h00) begin errors++; $display("FAIL d3_rd_oob got %h exp 00", data_out_b3); end
        checks++;
        if (data_out_b !== 8'h77) begin errors++; $display("FAIL d4_r3 got %h exp 77", data_out_b); end
        for (int i = 0; i < 3; i++) begin
            set_rd(2'(i), 2'd3);
            checks++;
            if (data_out_a3 !== 8'h00) begin errors++; $display("FAIL d3_r%0d got %h exp 00", i, data_out_a3); end
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_inc_dec();
        test_shift();
        test_no_bypass();
        test_clear_override();
        test_depth3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cb_register_bank.md
CB_REGISTER_BANK -- requirements
Module: cb_register_bank

Interface
REQ-001 Parameter WIDTH, default 8, data width of every register in bits (legal 2..32).
REQ-002 Parameter DEPTH, default 4, number of registers in the bank (legal 2..16).
REQ-003 Derived constant AW = max(1, clog2(DEPTH)), width of all address ports.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 clear  input  1  reset, synchronous and active-high.
REQ-006 op  input  3  operation code for this cycle (encoding per REQ-011).
REQ-007 wr_addr  input  AW  target register of op.
REQ-008 data_in  input  WIDTH  operand for LOAD.
REQ-009 rd_addr_a, rd_addr_b  input  AW each  read-port addresses.
REQ-010 data_out_a, data_out_b  output  WIDTH each  contents of the addressed registers; flag_zero  output  1; flag_carry  output  1.

Function
REQ-011 op encoding SHALL be: 0 NOP, 1 LOAD, 2 INC, 3 DEC, 4 SHL, 5 SHR, 6 CLR, 7 reserved (treated as NOP).
REQ-012 One op SHALL execute per cycle on register wr_addr; result written at the rising edge of the same cycle (latency 1).
REQ-013 LOAD: reg <= data_in; flag_carry <= 0.
REQ-014 INC: reg <= reg+1 mod 2^WIDTH; flag_carry <= 1 only when reg was all-ones (wrap to 0).
REQ-015 DEC: reg <= reg-1 mod 2^WIDTH; flag_carry (borrow) <= 1 only when reg was 0 (wrap to all-ones).
REQ-016 SHL: reg <= {reg[WIDTH-2:0],0}; flag_carry <= old reg[WIDTH-1].
REQ-017 SHR: logical, reg <= {0,reg[WIDTH-1:1]}; flag_carry <= old reg[0].
REQ-018 CLR: reg <= 0; flag_carry <= 0.
REQ-019 flag_zero SHALL be set to (new register value == 0) on every op 1..6.
REQ-020 NOP, reserved op and any op with wr_addr >= DEPTH SHALL leave all registers and both flags unchanged.
REQ-021 Read ports SHALL be combinational from stored state: a read of the register written this cycle returns the pre-edge value (no bypass).
REQ-022 Read address >= DEPTH SHALL return 0 on that port.
REQ-023 Both read ports SHALL operate independently and may address the same register.
REQ-024 Registers not addressed by wr_addr SHALL hold their value.

Reset
REQ-025 clear high at a rising edge SHALL set all registers, flag_zero and flag_carry to 0, overriding any op in that cycle.
REQ-026 clear asserted mid-sequence SHALL discard the in-cycle op; ops resume on the first edge with clear low.
REQ-027 Outputs after reset: data_out_a = data_out_b = 0, flag_zero = 0, flag_carry = 0.

Structure
REQ-028 Op-code constants (NOP..CLR) SHALL live in shared package cb_register_pkg, used by this block and the CPU control unit.
REQ-029 WIDTH, DEPTH remain module parameters; AW is a derived localparam, not a package constant.
REQ-030 Combinational next-value/carry computation SHALL be one sub-module, cb_reg_op_unit (inputs op, old value, data_in; outputs new value, carry, write-enable).
REQ-031 Storage, flags and read muxes SHALL reside in cb_register_bank.

Verification (WIDTH=8, DEPTH=4 unless stated)
REQ-032 clear 1 cycle, then LOAD r2=0xA5 -> next cycle data_out_a(rd 2)=0xA5, flag_zero=0, flag_carry=0; r0,r1,r3 read 0.
REQ-033 LOAD r1=0xFF, INC r1 -> r1=0x00, flag_carry=1, flag_zero=1; then DEC r1 -> r1=0xFF, flag_carry=1, flag_zero=0.
REQ-034 LOAD r3=0x81, SHL r3 -> 0x02, carry=1; SHR r3 -> 0x01, carry=0; SHR -> 0x00, carry=1, zero=1.
REQ-035 LOAD r0=0x10 while rd_addr_a=0 -> data_out_a=0x00 that cycle, 0x10 after edge; op=7 and wr_addr valid -> nothing changes.
REQ-036 DEPTH=3: LOAD to wr_addr=3 -> no register or flag change; rd_addr_b=3 -> data_out_b=0.
REQ-037 LOAD r2=0x33 with clear=1 same edge -> r2=0, flags 0; LOAD next cycle with clear=0 -> r2=0x33.
